// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// Carries the IR fields, the zero flag, every control strobe and the debug state code.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regwrite, regdst,
        output memtoreg, alusrca, alusrcb, pcsrc, alucontrol,
        output illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst,
        input  memtoreg, alusrca, alusrcb, pcsrc, alucontrol,
        input  illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore controller for the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Ports: clk, reset (sync, active-low), bus (master side: IR fields in, controls out).
module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur;
    state_t nxt;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk) begin
        if (!reset) cur <= FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt            = FETCH;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b010;
        bus.illegal    = 1'b0;

        case (cur)
            FETCH: begin
                nxt         = DECODE;
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
            end
            DECODE: begin
                // ALU precomputes the branch target into ALUOut
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default: begin
                        nxt         = FETCH;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                nxt         = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMREAD: begin
                nxt      = MEMWB;
                bus.iord = 1'b1;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEMWRITE: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXECUTE: begin
                nxt         = ALUWB;
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            ALUWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                branch         = 1'b1;
                bus.pcsrc      = 2'b01;
            end
            ADDIEX: begin
                nxt         = ADDIWB;
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            JUMP: begin
                pcwrite   = 1'b1;
                bus.pcsrc = 2'b10;
            end
            default: begin
                // unused codes 12-15 recover to FETCH with everything idle
                nxt            = FETCH;
                bus.alucontrol = 3'b000;
            end
        endcase

        // Reset cycle: FETCH-style steering, but no write strobes escape
        if (!reset) begin
            pcwrite        = 1'b0;
            branch         = 1'b0;
            bus.iord       = 1'b0;
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regwrite   = 1'b0;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b01;
            bus.pcsrc      = 2'b00;
            bus.alucontrol = 3'b010;
            bus.illegal    = 1'b0;
        end
    end

    assign bus.pcen  = pcwrite | (branch & bus.zero);
    assign bus.state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller.
// Expected state/output vectors are queued at drive time and popped each cycle.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] o;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    // {pcen,iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,
    //  alusrcb[1:0],pcsrc[1:0],alucontrol[2:0],illegal}
    function automatic logic [15:0] model(input logic [3:0] st,
                                          input logic [5:0] op,
                                          input logic [5:0] fn,
                                          input logic z,
                                          input logic rn);
        logic pcen, iord, mw, irw, rw, rd, mtr, asa, ill;
        logic [1:0] srcb, psrc;
        logic [2:0] aluc;
        pcen = 0; iord = 0; mw = 0; irw = 0; rw = 0; rd = 0;
        mtr = 0; asa = 0; ill = 0; srcb = 2'b00; psrc = 2'b00;
        aluc = 3'b010;
        if (!rn) begin
            srcb = 2'b01;
        end else begin
            case (st)
                4'd0: begin irw = 1; pcen = 1; srcb = 2'b01; end
                4'd1: begin
                    srcb = 2'b11;
                    ill = !(op == 6'b100011 || op == 6'b101011 ||
                            op == 6'b000000 || op == 6'b000100 ||
                            op == 6'b001000 || op == 6'b000010);
                end
                4'd2, 4'd9: begin asa = 1; srcb = 2'b10; end
                4'd3: iord = 1;
                4'd4: begin rw = 1; mtr = 1; end
                4'd5: begin iord = 1; mw = 1; end
                4'd6: begin
                    asa = 1;
                    case (fn)
                        6'b100010: aluc = 3'b110;
                        6'b100100: aluc = 3'b000;
                        6'b100101: aluc = 3'b001;
                        6'b101010: aluc = 3'b111;
                        default:   aluc = 3'b010;
                    endcase
                end
                4'd7: begin rw = 1; rd = 1; end
                4'd8: begin asa = 1; aluc = 3'b110; psrc = 2'b01; pcen = z; end
                4'd10: rw = 1;
                4'd11: begin pcen = 1; psrc = 2'b10; end
                default: aluc = 3'b000;
            endcase
        end
        return {pcen, iord, mw, irw, rw, rd, mtr, asa, srcb, psrc, aluc, ill};
    endfunction

    task automatic push(input string tag, input logic [3:0] st, input logic rn);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.o   = model(st, bus.op, bus.funct, bus.zero, rn);
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t e;
        logic [15:0] act;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL scoreboard_empty got 0 entries want >0");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite,
                   bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                   bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
            assert (bus.state === e.st) else begin
                mismatched++;
                $error("FAIL %s_state got %0d want %0d", e.tag, bus.state, e.st);
            end
            compared++;
            assert (act === e.o) else begin
                mismatched++;
                $error("FAIL %s_outs(st=%0d) got %h want %h",
                       e.tag, e.st, act, e.o);
            end
        end
    endtask

    // seq holds n state codes, one per nibble, first state in the top nibble
    task automatic run(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input logic [31:0] seq, input int n);
        bus.op = op;
        bus.funct = fn;
        bus.zero = z;
        for (int i = 0; i < n; i++)
            push(tag, seq[(n - 1 - i) * 4 +: 4], 1'b1);
        for (int i = 0; i < n; i++) begin
            #1 check_one();
            @(negedge clk);
        end
    endtask

    initial begin
        bus.op = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;

        repeat (3) @(negedge clk);
        push("reset", 4'd0, 1'b0);
        #1 check_one();
        reset = 1'b1;

        run("lw",    6'b100011, 6'd0, 1'b0, 32'h01234, 5);
        run("sw",    6'b101011, 6'd0, 1'b0, 32'h0125, 4);
        run("add",   6'b000000, 6'b100000, 1'b0, 32'h0167, 4);
        run("sub",   6'b000000, 6'b100010, 1'b0, 32'h0167, 4);
        run("and",   6'b000000, 6'b100100, 1'b0, 32'h0167, 4);
        run("or",    6'b000000, 6'b100101, 1'b0, 32'h0167, 4);
        run("slt",   6'b000000, 6'b101010, 1'b0, 32'h0167, 4);
        run("rdflt", 6'b000000, 6'b111111, 1'b0, 32'h0167, 4);
        run("beq_t", 6'b000100, 6'd0, 1'b1, 32'h018, 3);
        run("beq_n", 6'b000100, 6'd0, 1'b0, 32'h018, 3);
        run("addi",  6'b001000, 6'd0, 1'b0, 32'h019a, 4);
        run("j",     6'b000010, 6'd0, 1'b0, 32'h01b, 3);
        run("ill",   6'b111111, 6'd0, 1'b1, 32'h01, 2);

        // abort a sw in MEMADR with a reset held over two edges
        bus.op = 6'b101011;
        bus.funct = 6'd0;
        bus.zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push("abort", 4'd2, 1'b0);
        #1 check_one();
        repeat (2) begin
            @(negedge clk);
            push("abort_rst", 4'd0, 1'b0);
            #1 check_one();
        end
        @(negedge clk);
        reset = 1'b1;
        run("post", 6'b100011, 6'd0, 1'b0, 32'h01234, 5);

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_left got %0d want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit that sequences the multicycle MIPS datapath: the shared instruction/data memory, instruction register, register file, ALU and PC registers. It is a Moore state machine that decodes the opcode held in the instruction register and walks each instruction through fetch, decode, execute, memory and writeback steps. It also drives the combined PC enable and the 3-bit ALU control. It replaces the single-cycle main decoder when the core moves to the multicycle datapath.

## Interface
- No parameters; opcode and funct widths are fixed by the ISA.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regwrite  out  1  register file write enable
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = Data register
- alusrca  out  1  ALU A: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B: 00 = B register, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle flag, high in DECODE for an unsupported opcode
- state  out  4  current state code, for debug/verification

## Operation
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- States, with codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j), FETCH (other; illegal=1).
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP→FETCH.
  - Codes 12–15→FETCH.
- Outputs per state. Any output not listed is 0; alucontrol is 010 unless stated.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, pcsrc=00.
  - DECODE: alusrcb=11 (branch target into ALUOut).
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10.
  - MEMREAD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWRITE: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00; alucontrol from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010.
  - ALUWB: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, alusrcb=00, alucontrol=110, branch=1, pcsrc=01.
  - ADDIWB: regwrite=1.
  - JUMP: pcwrite=1, pcsrc=10.
  - Codes 12–15: all outputs 0.
- op and funct are sampled only in DECODE, MEMADR and EXECUTE. The IR is stable then because irwrite is only asserted in FETCH.

## Timing
- The state register updates on the rising clk edge. All outputs except pcen are Moore, decoded combinationally from the state register.
- pcen is combinational from state and zero, and is valid in the same cycle as the BRANCH state.
- Reset: when reset=0 at a rising edge, state←FETCH.
- While reset=0, memwrite, irwrite, regwrite, pcen and illegal are forced to 0 regardless of state. The other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it. No write-enable pulse is produced in the reset cycle.
- Cycles per instruction, counted from the FETCH cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- No handshakes and no stalls; memory is assumed to respond in one cycle.

## Test plan
- Reset: hold reset=0 for 3 cycles from an arbitrary state → state=0, irwrite=pcwrite=regwrite=memwrite=0 during reset. On the first cycle after release: irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011) → state sequence 0,1,2,3,4,0. iord=1 only in state 3; regwrite=1 with memtoreg=1 only in state 4.
- sw (op=101011) → sequence 0,1,2,5,0. memwrite=1 for exactly one cycle, with iord=1; regwrite never asserted.
- R-type with each of funct 100000/100010/100100/100101/101010 → sequence 0,1,6,7,0. alucontrol in state 6 is 010/110/000/001/111 respectively; regwrite=1 with regdst=1 in state 7.
- beq (op=000100): with zero=1 → pcen=1 and pcsrc=01 in state 8; with zero=0 → pcen=0. Both cases return to state 0.
- j (op=000010) → sequence 0,1,11,0 with pcen=1, pcsrc=10 in state 11. Illegal op=111111 → sequence 0,1,0 with illegal=1 for one cycle and no write enables asserted.
